// File: rtl/bus_pkg.sv
// Shared types and constants for the N-master valid/ready bus arbiter.
package bus_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int BUS_MAX_DATA_W = 1024;

  // Read data returned to a master when the watchdog terminates its transaction.
  function automatic logic [BUS_MAX_DATA_W-1:0] bus_err_data();
    return '1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester searching upward from last_grant+1.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_last_grant,
  output logic [IDX_W-1:0]       o_grant,
  output logic                   o_any_req
);

  always_comb begin
    o_grant   = '0;
    o_any_req = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(i_last_grant) + k) % NUM_MASTERS;
      if (!o_any_req && i_req[idx]) begin
        o_any_req = 1'b1;
        o_grant   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// N-master to 1-slave valid/ready bus arbiter with round-robin grant locking.
// Optional watchdog abort enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SW            = DATA_W / 8,
  localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_instr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
  input  logic [NUM_MASTERS*SW-1:0]     m_wstrb,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_read_data,
  output logic                          s_valid,
  output logic                          s_instr,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_write_data,
  output logic [SW-1:0]                 s_wstrb,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_read_data,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic                          bus_err
);

  if (NUM_MASTERS < 2)     $error("bus_arbiter: NUM_MASTERS must be >= 2");
  if (DATA_W % 8 != 0)     $error("bus_arbiter: DATA_W must be a multiple of 8");
  if (TIMEOUT_CYCLES < 1)  $error("bus_arbiter: TIMEOUT_CYCLES must be >= 1");

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_last_grant;

  logic [IDX_W-1:0] w_rr_grant;
  logic             w_any_req;
  logic             w_busy;
  logic             w_gnt_valid;
  logic             w_done;
  logic             w_abort;
  logic             w_timeout;
  logic [DATA_W-1:0] w_err_data;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .i_req        (m_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_rr_grant),
    .o_any_req    (w_any_req)
  );

  assign w_busy      = (r_state == BUSY);
  assign w_gnt_valid = m_valid[r_grant_idx];
  assign w_done      = w_busy && w_gnt_valid && s_ready;
  assign w_abort     = w_busy && !w_gnt_valid;
  assign w_err_data  = DATA_W'(bus_err_data());

  assign grant_idx = r_grant_idx;
  assign busy      = w_busy;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] r_wd_cnt;
  logic [CNT_W-1:0] w_wd_cnt_inc;

  // r_wd_cnt holds unanswered cycles before this one; the increment includes this cycle.
  assign w_wd_cnt_inc = r_wd_cnt + CNT_W'(1);
  assign w_timeout    = w_busy && w_gnt_valid && !s_ready &&
                        (w_wd_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  assign bus_err      = w_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (!w_busy) begin
      r_wd_cnt <= '0;
    end else if (!s_ready) begin
      r_wd_cnt <= w_wd_cnt_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_comb begin
    s_valid      = w_busy && w_gnt_valid;
    s_instr      = 1'b0;
    s_addr       = '0;
    s_write_data = '0;
    s_wstrb      = '0;
    m_ready      = '0;
    m_read_data  = w_timeout ? w_err_data : s_read_data;
    if (w_busy) begin
      s_instr      = m_instr[r_grant_idx];
      s_addr       = m_addr[int'(r_grant_idx)*ADDR_W +: ADDR_W];
      s_write_data = m_write_data[int'(r_grant_idx)*DATA_W +: DATA_W];
      s_wstrb      = m_wstrb[int'(r_grant_idx)*SW +: SW];
    end
    if (w_done || w_timeout) begin
      m_ready[r_grant_idx] = 1'b1;
    end
  end

  // Reset leaves last_grant at the top master so master 0 wins the first round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_idx  <= w_rr_grant;
            r_last_grant <= w_rr_grant;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (w_done || w_abort || w_timeout) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with four masters.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      m_valid;
  logic [N-1:0]      m_instr;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_write_data;
  logic [N*SW-1:0]   m_wstrb;
  logic [N-1:0]      m_ready;
  logic [DW-1:0]     m_read_data;
  logic              s_valid;
  logic              s_instr;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_write_data;
  logic [SW-1:0]     s_wstrb;
  logic              s_ready;
  logic [DW-1:0]     s_read_data;
  logic [1:0]        grant_idx;
  logic              busy;
  logic              bus_err;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_valid      (m_valid),
    .m_instr      (m_instr),
    .m_addr       (m_addr),
    .m_write_data (m_write_data),
    .m_wstrb      (m_wstrb),
    .m_ready      (m_ready),
    .m_read_data  (m_read_data),
    .s_valid      (s_valid),
    .s_instr      (s_instr),
    .s_addr       (s_addr),
    .s_write_data (s_write_data),
    .s_wstrb      (s_wstrb),
    .s_ready      (s_ready),
    .s_read_data  (s_read_data),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_valid[i]              = v;
    m_addr[i*AW +: AW]      = a;
    m_write_data[i*DW +: DW] = d;
    m_wstrb[i*SW +: SW]     = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_valid = '0; m_instr = '0; m_addr = '0; m_write_data = '0;
    m_wstrb = '0; s_ready = 1'b0; s_read_data = '0;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_idx); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_s_valid got=%b want=0", s_valid); end
    total++; if (m_ready !== 4'b0000) begin bad++; $display("FAIL reset_m_ready got=%b want=0000", m_ready); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%b want=0", bus_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    set_m(1, 1'b1, 32'h100, 32'h0, 4'b0000);
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rd_pre_s_valid got=%b want=0", s_valid); end
    step();
    total++; if (busy !== 1'b1 || grant_idx !== 2'd1) begin bad++; $display("FAIL rd_grant got=%b/%0d want=1/1", busy, grant_idx); end
    total++; if (s_valid !== 1'b1 || s_addr !== 32'h100 || s_wstrb !== 4'b0000) begin bad++; $display("FAIL rd_s_bus got=%b/%h/%b want=1/00000100/0000", s_valid, s_addr, s_wstrb); end
    total++; if (m_ready !== 4'b0000) begin bad++; $display("FAIL rd_wait1 got=%b want=0000", m_ready); end
    step();
    total++; if (m_ready !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL rd_wait2 got=%b/%b want=0000/1", m_ready, busy); end
    step();
    s_ready = 1'b1; s_read_data = 32'hCAFEF00D;
    #1;
    total++; if (m_ready !== 4'b0010) begin bad++; $display("FAIL rd_ready got=%b want=0010", m_ready); end
    total++; if (m_read_data !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_data got=%h want=cafef00d", m_read_data); end
    step();
    set_m(1, 1'b0, 32'h0, 32'h0, 4'b0000); s_ready = 1'b0;
    #1;
    total++; if (m_ready !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rd_pulse_end got=%b/%b want=0000/0", m_ready, busy); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd0; exp_g[3] = 2'd1;
    set_m(0, 1'b1, 32'hA0, 32'h0, 4'b0000);
    set_m(1, 1'b1, 32'hB0, 32'h0, 4'b0000);
    s_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      total++; if (busy !== 1'b1 || grant_idx !== exp_g[n]) begin bad++; $display("FAIL b2b_grant%0d got=%b/%0d want=1/%0d", n, busy, grant_idx, exp_g[n]); end
      total++; if (m_ready !== (4'b0001 << exp_g[n])) begin bad++; $display("FAIL b2b_ready%0d got=%b want=%b", n, m_ready, 4'b0001 << exp_g[n]); end
      if (n == 3) begin m_valid = '0; s_ready = 1'b0; end
      step();
      total++; if (busy !== 1'b0 || s_valid !== 1'b0) begin bad++; $display("FAIL b2b_dead%0d got=%b/%b want=0/0", n, busy, s_valid); end
    end
    step();
  endtask

  task automatic test_wrap();
    set_m(3, 1'b1, 32'h300, 32'h0, 4'b0000);
    step();
    total++; if (grant_idx !== 2'd3) begin bad++; $display("FAIL wrap_g3 got=%0d want=3", grant_idx); end
    s_ready = 1'b1; #1;
    total++; if (m_ready !== 4'b1000) begin bad++; $display("FAIL wrap_r3 got=%b want=1000", m_ready); end
    step();
    m_valid[3] = 1'b0; s_ready = 1'b0;
    set_m(0, 1'b1, 32'h10, 32'h0, 4'b0000);
    set_m(2, 1'b1, 32'h20, 32'h0, 4'b0000);
    step();
    total++; if (grant_idx !== 2'd0 || s_addr !== 32'h10) begin bad++; $display("FAIL wrap_g0 got=%0d/%h want=0/00000010", grant_idx, s_addr); end
    s_ready = 1'b1; #1;
    total++; if (m_ready !== 4'b0001) begin bad++; $display("FAIL wrap_r0 got=%b want=0001", m_ready); end
    step();
    m_valid[0] = 1'b0; s_ready = 1'b0;
    step();
    total++; if (grant_idx !== 2'd2 || s_addr !== 32'h20) begin bad++; $display("FAIL wrap_g2 got=%0d/%h want=2/00000020", grant_idx, s_addr); end
    s_ready = 1'b1; #1;
    total++; if (m_ready !== 4'b0100) begin bad++; $display("FAIL wrap_r2 got=%b want=0100", m_ready); end
    step();
    m_valid[2] = 1'b0; s_ready = 1'b0;
    step();
  endtask

  task automatic test_abort();
    set_m(0, 1'b1, 32'h40, 32'h1234, 4'b0011);
    m_instr[0] = 1'b1;
    step();
    total++; if (grant_idx !== 2'd0 || s_valid !== 1'b1 || s_instr !== 1'b1) begin bad++; $display("FAIL ab_grant got=%0d/%b/%b want=0/1/1", grant_idx, s_valid, s_instr); end
    total++; if (s_wstrb !== 4'b0011 || s_write_data !== 32'h1234) begin bad++; $display("FAIL ab_write got=%b/%h want=0011/00001234", s_wstrb, s_write_data); end
    m_valid[0] = 1'b0; m_instr[0] = 1'b0; #1;
    total++; if (s_valid !== 1'b0 || m_ready !== 4'b0000) begin bad++; $display("FAIL ab_drop got=%b/%b want=0/0000", s_valid, m_ready); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_idle got=%b want=0", busy); end
    step();
  endtask

  task automatic test_timeout();
    set_m(2, 1'b1, 32'h200, 32'h0, 4'b0000);
    s_ready = 1'b0; s_read_data = 32'h12345678;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c < 4) begin
        total++; if (m_ready !== 4'b0000 || bus_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b/%b want=0000/0", c, m_ready, bus_err); end
      end else begin
        total++; if (m_ready !== 4'b0100 || bus_err !== 1'b1) begin bad++; $display("FAIL to_fire got=%b/%b want=0100/1", m_ready, bus_err); end
        total++; if (m_read_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL to_data got=%h want=ffffffff", m_read_data); end
      end
    end
    step();
    total++; if (busy !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL to_idle got=%b/%b want=0/0", busy, bus_err); end
    m_valid[2] = 1'b0;
`else
    for (int c = 1; c <= 6; c++) step();
    total++; if (busy !== 1'b1 || bus_err !== 1'b0 || m_ready !== 4'b0000) begin bad++; $display("FAIL to_hold got=%b/%b/%b want=1/0/0000", busy, bus_err, m_ready); end
    total++; if (m_read_data !== 32'h12345678) begin bad++; $display("FAIL to_passthru got=%h want=12345678", m_read_data); end
    m_valid[2] = 1'b0;
    step();
`endif
    step();
  endtask

  task automatic test_reset_mid();
    set_m(1, 1'b1, 32'h500, 32'h0, 4'b0000);
    step();
    total++; if (busy !== 1'b1 || grant_idx !== 2'd1) begin bad++; $display("FAIL rm_grant got=%b/%0d want=1/1", busy, grant_idx); end
    rst_n = 1'b0;
    step();
    total++; if (s_valid !== 1'b0 || busy !== 1'b0 || grant_idx !== 2'd0) begin bad++; $display("FAIL rm_reset got=%b/%b/%0d want=0/0/0", s_valid, busy, grant_idx); end
    set_m(0, 1'b1, 32'h600, 32'h0, 4'b0000);
    rst_n = 1'b1;
    step();
    total++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin bad++; $display("FAIL rm_first got=%b/%0d want=1/0", busy, grant_idx); end
    m_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
